// File: rtl/key_switch_controller.sv
// Push-button / slide-switch MMIO peripheral: two-flop synchronisers, per-key
// debounce, latched press/release events with W1C clear, and a masked press interrupt.
module key_switch_controller #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:0]  key_n,
  input  logic [9:0]  switch,
  input  logic [2:0]  address,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        interrupt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] COUNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  localparam logic [2:0] ADDR_KEY_STATE = 3'd0;
  localparam logic [2:0] ADDR_SWITCH    = 3'd1;
  localparam logic [2:0] ADDR_PRESS     = 3'd2;
  localparam logic [2:0] ADDR_RELEASE   = 3'd3;
  localparam logic [2:0] ADDR_MASK      = 3'd4;

  logic [3:0]    key_sync_p0, key_sync_p1;
  logic [9:0]    switch_sync_p0, switch_sync_p1;
  logic [3:0]    stable;
  logic [CW-1:0] count [4];
  logic [3:0]    toggle;
  logic [3:0]    press_set, release_set;
  logic [3:0]    press_pending, release_pending, mask;
  logic [3:0]    press_clr, release_clr;
  logic [31:0]   read_word;
  logic          unused_write_bits;

  assign unused_write_bits = ^write_data[31:4];

  // Stage p0/p1: synchronisers; keys idle high (released)
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      key_sync_p0    <= 4'hF;
      key_sync_p1    <= 4'hF;
      switch_sync_p0 <= '0;
      switch_sync_p1 <= '0;
    end else begin
      key_sync_p0    <= key_n;
      key_sync_p1    <= key_sync_p0;
      switch_sync_p0 <= switch;
      switch_sync_p1 <= switch_sync_p0;
    end
  end

  always_comb begin
    toggle = '0;
    for (int i = 0; i < 4; i++)
      toggle[i] = (key_sync_p1[i] != stable[i]) && (count[i] == COUNT_MAX);
  end

  // Debounce: count consecutive differing samples, accept on the last one
  always_ff @(posedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (!reset_n) begin
        count[i]  <= '0;
        stable[i] <= 1'b1;
      end else if (key_sync_p1[i] == stable[i]) begin
        count[i] <= '0;
      end else if (toggle[i]) begin
        count[i]  <= '0;
        stable[i] <= ~stable[i];
      end else begin
        count[i] <= count[i] + 1'b1;
      end
    end
  end

  assign press_set   = toggle & stable;
  assign release_set = toggle & ~stable;
  assign press_clr   = (write_enable && address == ADDR_PRESS)   ? write_data[3:0] : 4'h0;
  assign release_clr = (write_enable && address == ADDR_RELEASE) ? write_data[3:0] : 4'h0;

  // New events are OR-ed in after the clear so a coincident set survives
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      press_pending   <= '0;
      release_pending <= '0;
      mask            <= '0;
      interrupt       <= 1'b0;
    end else begin
      press_pending   <= (press_pending & ~press_clr) | press_set;
      release_pending <= (release_pending & ~release_clr) | release_set;
      if (write_enable && address == ADDR_MASK)
        mask <= write_data[3:0];
      interrupt <= |(press_pending & mask);
    end
  end

  always_comb begin
    read_word = '0;
    case (address)
      ADDR_KEY_STATE: read_word = {28'b0, ~stable};
      ADDR_SWITCH:    read_word = {22'b0, switch_sync_p1};
      ADDR_PRESS:     read_word = {28'b0, press_pending};
      ADDR_RELEASE:   read_word = {28'b0, release_pending};
      ADDR_MASK:      read_word = {28'b0, mask};
      default:        read_word = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n)
      read_data <= '0;
    else if (read_enable)
      read_data <= read_word;
  end

endmodule

// File: doc/key_switch_controller.md
# key_switch_controller

Memory-mapped input peripheral that receives the board push-buttons (`KEY`, active-low) and slide switches (`SW`) driven at the top level. It synchronises and debounces each key, latches press and release events, and exposes state, events and an interrupt to the core's MMIO bus. It sits between the `fpga_top` pins and the data-memory bus decoder. This is the consumer of the key-press sequences the top-level bench generates.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable cycles required to accept a key change (1 ms at 50 MHz). Legal range is ≥2. The counter width is `$clog2(DEBOUNCE_CYCLES)`.

Ports:
- `clock` input 1: system clock. One clock; reset is synchronous and active-low.
- `reset_n` input 1: synchronous, active-low reset.
- `key_n` input 4: raw push-buttons, asynchronous, 0 = pressed.
- `switch` input 10: raw slide switches, asynchronous.
- `address` input 3: word select within the peripheral.
- `read_enable` input 1: bus read strobe.
- `write_enable` input 1: bus write strobe.
- `write_data` input 32: bus write data.
- `read_data` output 32: registered read data.
- `interrupt` output 1: registered level interrupt.

## Operation
- **Synchronisers.** Two flops per bit.
  - Key synchronisers reset to 1 (released).
  - Switch synchronisers reset to 0.
  - Switches are not debounced.
- **Debounce, per key.** Each key has `stable[i]` (reset 1) and `count[i]` (reset 0).
  - If `sync[i] == stable[i]`, `count` clears.
  - Otherwise `count` increments.
  - When `count == DEBOUNCE_CYCLES-1` and `sync` still differs, `stable[i]` toggles and `count` clears.
- **Event detection.**
  - A `stable` transition 1→0 sets `press_pending[i]`.
  - A `stable` transition 0→1 sets `release_pending[i]`.
- **Register map.** Word addresses:
  - 0 KEY_STATE: `{28'b0, ~stable}`, read-only.
  - 1 SWITCH: `{22'b0, switch_sync}`, read-only.
  - 2 PRESS_EVENTS: `{28'b0, press_pending}`. Writing 1 to a bit clears it.
  - 3 RELEASE_EVENTS: `{28'b0, release_pending}`. Writing 1 to a bit clears it.
  - 4 IRQ_MASK: `{28'b0, mask}`, read/write. Reset value 0.
  - 5–7: read 0. Writes are ignored.
- **Interrupt.** `interrupt` is registered from `|(press_pending & mask)`. Release events never interrupt.
- **Set/clear priority.** If a new event and a W1C to the same bit occur in the same cycle, the set wins and the bit stays 1.
- **Bus strobes.**
  - Reads have no side effects.
  - When `read_enable` is low, `read_data` holds its last value.
  - If `read_enable` and `write_enable` are both high, the write takes effect. `read_data` returns the pre-write value.
- **Reset values.** On `reset_n` = 0 at a clock edge, regardless of any debounce in progress, the following all return to reset values in that cycle:
  - `read_data` = 0, `interrupt` = 0.
  - All pending bits, `mask`, `count` = 0.
  - `stable` = 1.

## Timing
- **Key change latency.** Take `key_n[i]` changed and held from edge N:
  - `sync[i]` reflects the change at N+2.
  - `stable[i]` and the pending bit update at edge N+2+`DEBOUNCE_CYCLES`.
  - `interrupt` asserts one cycle later.
- **Glitches.** A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no state change and no event. Its counter restarts from 0 on the next differing sample.
- **Read latency.** `read_data` is valid on the edge after `read_enable` is sampled (1-cycle latency). It reflects register contents before any same-cycle update.
- **Write-to-state latency.** A write updates state at the sampling edge. `interrupt` reflects a W1C or mask write one cycle later.
- **Independence.** All four keys debounce independently. Simultaneous transitions on several keys set all corresponding pending bits in the same cycle.
- **Counter range.** The counter never wraps, because it saturates at `DEBOUNCE_CYCLES-1` by construction.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
1. **Reset state.** Apply reset, then read addresses 0–4 → 0, 0, 0, 0, 0. `interrupt` = 0.
2. **Press with interrupt.** Write IRQ_MASK = 0x1, then hold `key_n` = 4'b1110 from edge N:
   - KEY_STATE = 0x1 and PRESS_EVENTS = 0x1 from edge N+6.
   - `interrupt` = 1 at N+7.
3. **Glitch rejection.** Pulse `key_n[1]` low for 3 cycles → KEY_STATE and PRESS_EVENTS remain 0.
4. **Release with W1C.**
   - Release key 0 → RELEASE_EVENTS = 0x1 and KEY_STATE = 0.
   - Write 0x1 to address 2 → PRESS_EVENTS = 0, and `interrupt` drops one cycle later.
5. **Set beats clear.** Issue a W1C to PRESS_EVENTS bit 2 in the exact cycle key 2's `stable` falls → the bit reads 1 afterwards.
6. **Switches, unmapped address, mid-debounce reset.**
   - Set `switch` = 10'b0000000010 → SWITCH reads 0x2 after 2 cycles plus read latency.
   - Read address 6 → 0.
   - Assert `reset_n` = 0 mid-debounce → KEY_STATE = 0, and no event after reset is released.
